transient_shaper_ctrl: RTL and testbench
========================================

// Module: transient_shaper_ctrl
// PURPOSE
// - Controller for the transient-shaper datapath: generates the sample-rate enable strobe and
//   drives the attack/sustain boost selects of the shaper core.
// - Auto mode: onset detector plus hold-timer FSM drives the boosts (attack burst, then
//   sustain tail). Manual mode passes host bits through. Sits between host config and the core.
// PARAMETERS
// - WIDTH   6  sample width of audio_in, thresh
// - DIV_W   8  width of the sample-rate divider
// - HOLD_W  8  width of the attack/sustain hold counters
// PORTS
// - clk          in   1       system clock
// - rst          in   1       asynchronous, active-high reset
// - ena          in   1       global enable; low freezes all state
// - div_val      in   DIV_W   strobe period minus 1
// - audio_in     in   WIDTH   unsigned sample (same bus as the core input)
// - thresh       in   WIDTH   onset rise threshold
// - attack_hold  in   HOLD_W  ATTACK length, in strobes minus 1
// - sustain_hold in   HOLD_W  SUSTAIN length, in strobes minus 1
// - mode         in   2       00=off, 01=manual, 10=auto, 11=off
// - man_attack   in   1       manual attack select
// - man_sustain  in   1       manual sustain select
// - core_ena     out  1       one-cycle sample strobe to the core
// - attack_amt   out  1       attack boost select to the core
// - sustain_amt  out  1       sustain boost select to the core
// - state_o      out  2       FSM state: 0=IDLE, 1=ATTACK, 2=SUSTAIN
// - onset        out  1       one-cycle pulse on a detected onset
// BEHAVIOUR
// - Reset: every output 0; state IDLE; divider count 0; prev sample 0; hold count 0.
// - All state updates require ena=1. With ena=0, everything holds and core_ena=0.
// - Divider: counts 0..div_val. core_ena=1 for the cycle in which count==div_val, then count
//   wraps to 0. div_val=0 gives core_ena=1 every cycle.
// - Strobe cycle: a cycle with ena=1 and core_ena=1. Onset, prev and FSM update only on
//   strobe cycles.
// - Onset test: compute in WIDTH+1 bits, no wrap: rise = audio_in - prev.
//   onset_det = (audio_in > prev) && (rise > thresh), strict.
//   prev <= audio_in on every strobe, in any mode.
// - onset output: registered; high the cycle after the strobe where onset_det=1 (auto mode only).
// - FSM, auto mode, per strobe:
//   IDLE: onset_det -> ATTACK, hold count <= attack_hold.
//   ATTACK: onset_det -> reload attack_hold and stay (retrigger). Else count==0 -> SUSTAIN
//     with count <= sustain_hold. Else decrement.
//   SUSTAIN: onset_det -> ATTACK with count <= attack_hold. Else count==0 -> IDLE.
//     Else decrement.
//   Onset and expiry on the same strobe: onset wins.
// - Each state lasts hold+1 strobes.
// - mode != auto: state forced to IDLE and count to 0 on the next clk edge (ena=1), strobe or not.
// - Outputs are registered, updated the cycle after the deciding strobe or mode change.
//   auto: attack_amt = (state==ATTACK), sustain_amt = (state==SUSTAIN).
//   manual: attack_amt = man_attack, sustain_amt = man_sustain.
//   off: both 0.
// - Hold values are sampled only at load. Changes mid-state take effect at the next load.
// - Reset mid-burst: immediate return to reset values. The first strobe after reset comes
//   div_val+1 enabled cycles later.
// CONFIGURATION
// - TS_ONSET_COUNT_EN defined: adds onset_clr (in, 1) and onset_count (out, 8).
//   onset_count is a saturating count of onset pulses; it holds at 255.
//   onset_clr=1 clears it to 0 and takes priority over a same-cycle increment.
//   The counter resets to 0.
// - TS_ONSET_COUNT_EN undefined: both ports are absent; no counter logic.
// TESTING
// - Reset check: rst=1 with random inputs -> all outputs 0. Release with div_val=3, ena=1 ->
//   core_ena high on cycles 4, 8, 12.
// - Enable gating: ena=0 for 5 cycles mid-period -> core_ena stays 0 and the strobe phase
//   resumes unchanged.
// - Onset threshold: auto, div_val=0, thresh=10, prev=5, audio_in=15 -> no onset.
//   audio_in=16 -> onset pulse, attack_amt=1 on the next cycle.
// - Burst timing: auto, attack_hold=2, sustain_hold=3, one onset -> attack_amt high
//   3 strobes, then sustain_amt high 4 strobes, then IDLE.
// - Retrigger and priority: onset on the final SUSTAIN strobe -> ATTACK with count=attack_hold,
//   not IDLE. Onset in ATTACK -> count reloaded.
// - Mode switch: auto mid-ATTACK -> manual (man_attack=0, man_sustain=1) -> next cycle
//   state_o=0, attack_amt=0, sustain_amt=1. With TS_ONSET_COUNT_EN, 300 onsets -> onset_count=255.

Source files
------------

// File: rtl/transient_shaper_ctrl.sv
// transient_shaper_ctrl
// Controller for the transient-shaper datapath. It divides the system clock
// down to a sample-rate strobe (core_ena) and drives the attack/sustain boost
// selects of the shaper core. In auto mode an onset detector and a hold-timer
// FSM produce an attack burst followed by a sustain tail. In manual mode the
// host select bits pass straight through. Any other mode turns both boosts off.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   ena             global enable; low freezes all state and blanks core_ena
//   div_val         strobe period minus 1
//   audio_in        unsigned sample, same bus as the core input
//   thresh          onset rise threshold
//   attack_hold     ATTACK length in strobes minus 1
//   sustain_hold    SUSTAIN length in strobes minus 1
//   mode            00 off, 01 manual, 10 auto, 11 off
//   man_attack      manual attack select
//   man_sustain     manual sustain select
//   core_ena        one-cycle sample strobe to the core
//   attack_amt      attack boost select (registered)
//   sustain_amt     sustain boost select (registered)
//   state_o         FSM state: 0 IDLE, 1 ATTACK, 2 SUSTAIN
//   onset           one-cycle pulse after a strobe with a detected onset
//
// Build option TS_ONSET_COUNT_EN adds onset_clr (in) and onset_count (out, 8),
// a saturating count of onset pulses that onset_clr clears.

module transient_shaper_ctrl #(
  parameter int WIDTH  = 6,
  parameter int DIV_W  = 8,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [DIV_W-1:0]  div_val,
  input  logic [WIDTH-1:0]  audio_in,
  input  logic [WIDTH-1:0]  thresh,
  input  logic [HOLD_W-1:0] attack_hold,
  input  logic [HOLD_W-1:0] sustain_hold,
  input  logic [1:0]        mode,
  input  logic              man_attack,
  input  logic              man_sustain,
`ifdef TS_ONSET_COUNT_EN
  input  logic              onset_clr,
  output logic [7:0]        onset_count,
`endif
  output logic              core_ena,
  output logic              attack_amt,
  output logic              sustain_amt,
  output logic [1:0]        state_o,
  output logic              onset
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [WIDTH-1:0]    prev_q;
  logic                onset_q, attack_q, sustain_q;
  logic                attack_d, sustain_d;

  logic                strobe;
  logic                autoMode;
  logic                manualMode;
  logic [WIDTH:0]      rise;
  logic                onsetDet;
  logic                onsetHit;

  assign autoMode   = (mode == 2'b10);
  assign manualMode = (mode == 2'b01);

  // Strobe fires on the terminal divider count. Reset is folded in so that a
  // div_val of 0 cannot leak a strobe while the block is held in reset.
  assign strobe   = ena && (div_q == div_val);
  assign core_ena = strobe && !rst;

  // Rise is formed one bit wider so a falling sample cannot wrap into a
  // large positive value.
  assign rise     = {1'b0, audio_in} - {1'b0, prev_q};
  assign onsetDet = (audio_in > prev_q) && (rise > {1'b0, thresh});
  assign onsetHit = strobe && autoMode && onsetDet;

  // Next-state logic for divider, hold FSM and the registered boost selects.
  // Leaving auto mode parks the FSM in IDLE on the next enabled edge even
  // without a strobe; an onset always beats hold expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = strobe ? '0 : div_q + DIV_W'(1);

    if (!autoMode) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (strobe) begin
      case (state_q)
        IDLE: begin
          if (onsetDet) begin
            state_d = ATTACK;
            cnt_d   = attack_hold;
          end
        end
        ATTACK: begin
          if (onsetDet) begin
            cnt_d = attack_hold;
          end else if (cnt_q == '0) begin
            state_d = SUSTAIN;
            cnt_d   = sustain_hold;
          end else begin
            cnt_d = cnt_q - HOLD_W'(1);
          end
        end
        SUSTAIN: begin
          if (onsetDet) begin
            state_d = ATTACK;
            cnt_d   = attack_hold;
          end else if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - HOLD_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (autoMode) begin
      attack_d  = (state_d == ATTACK);
      sustain_d = (state_d == SUSTAIN);
    end else begin
      attack_d  = manualMode && man_attack;
      sustain_d = manualMode && man_sustain;
    end
  end

  // State registers; everything holds while ena is low. The previous sample
  // tracks every strobe regardless of mode so auto mode starts from a fresh
  // reference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      prev_q    <= '0;
      onset_q   <= 1'b0;
      attack_q  <= 1'b0;
      sustain_q <= 1'b0;
    end else if (ena) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      onset_q   <= onsetHit;
      attack_q  <= attack_d;
      sustain_q <= sustain_d;
      if (strobe) begin
        prev_q <= audio_in;
      end
    end
  end

  assign state_o     = state_q;
  assign onset       = onset_q;
  assign attack_amt  = attack_q;
  assign sustain_amt = sustain_q;

`ifdef TS_ONSET_COUNT_EN
  logic [7:0] ocnt_q;

  // Saturating onset counter; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ocnt_q <= '0;
    end else if (ena) begin
      if (onset_clr) begin
        ocnt_q <= '0;
      end else if (onsetHit && (ocnt_q != 8'hFF)) begin
        ocnt_q <= ocnt_q + 8'd1;
      end
    end
  end

  assign onset_count = ocnt_q;
`endif

endmodule

// File: tb/tb_transient_shaper_ctrl.sv
// tb_transient_shaper_ctrl
// Self-checking bench for transient_shaper_ctrl: a reset/strobe phase check,
// a table of single-cycle vectors, hand-written burst/retrigger/mode sequences
// and a randomized run against a behavioural model.
// Build option TS_ONSET_COUNT_EN also exercises onset_clr/onset_count.

module tb_transient_shaper_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] div_val;
  logic [5:0] audio_in;
  logic [5:0] thresh;
  logic [7:0] attack_hold;
  logic [7:0] sustain_hold;
  logic [1:0] mode;
  logic       man_attack;
  logic       man_sustain;
  logic       core_ena;
  logic       attack_amt;
  logic       sustain_amt;
  logic [1:0] state_o;
  logic       onset;
`ifdef TS_ONSET_COUNT_EN
  logic       onset_clr;
  logic [7:0] onset_count;
`endif

  int vecCnt = 0;
  int errCnt = 0;

  transient_shaper_ctrl #(.WIDTH(6), .DIV_W(8), .HOLD_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .div_val      (div_val),
    .audio_in     (audio_in),
    .thresh       (thresh),
    .attack_hold  (attack_hold),
    .sustain_hold (sustain_hold),
    .mode         (mode),
    .man_attack   (man_attack),
    .man_sustain  (man_sustain),
`ifdef TS_ONSET_COUNT_EN
    .onset_clr    (onset_clr),
    .onset_count  (onset_count),
`endif
    .core_ena     (core_ena),
    .attack_amt   (attack_amt),
    .sustain_amt  (sustain_amt),
    .state_o      (state_o),
    .onset        (onset)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       e;
    logic [1:0] m;
    logic [5:0] a;
    logic [5:0] t;
    logic       ma;
    logic       ms;
    logic       xCore;
    logic       xOnset;
    logic       xAtt;
    logic       xSus;
    logic [1:0] xSt;
  } vec_t;

  vec_t tbl [14];

  task automatic checkOutput(input string name, input int act, input int exp);
    vecCnt++;
    if (act != exp) begin
      errCnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [1:0] m, input logic [5:0] a,
                               input logic [5:0] t, input logic ma, input logic ms);
    ena         = e;
    mode        = m;
    audio_in    = a;
    thresh      = t;
    man_attack  = ma;
    man_sustain = ms;
  endtask

  task automatic clockEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    clockEdge();
    rst = 1'b0;
  endtask

  // Checks the registered outputs against an expected FSM state, deriving the
  // boost selects from it (auto mode only).
  task automatic checkAuto(input string tag, input int st, input int ons);
    checkOutput({tag, ".state"}, state_o, st);
    checkOutput({tag, ".attack"}, attack_amt, (st == 1) ? 1 : 0);
    checkOutput({tag, ".sustain"}, sustain_amt, (st == 2) ? 1 : 0);
    checkOutput({tag, ".onset"}, onset, ons);
  endtask

  // Behavioural model state for the random run.
  int mDiv, mPrev, mSt, mCnt, mOns, mAtt, mSus, mOcnt;

  initial begin
    int stSeq [15];
    int auSeq [15];
    int onSeq [15];

    tbl[0]  = '{1'b1, 2'b10, 6'd5,  6'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 2'b10, 6'd15, 6'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[2]  = '{1'b1, 2'b10, 6'd5,  6'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[3]  = '{1'b1, 2'b10, 6'd16, 6'd10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1};
    tbl[4]  = '{1'b1, 2'b10, 6'd16, 6'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[5]  = '{1'b1, 2'b10, 6'd16, 6'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2};
    tbl[6]  = '{1'b1, 2'b10, 6'd16, 6'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2};
    tbl[7]  = '{1'b1, 2'b10, 6'd16, 6'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[8]  = '{1'b1, 2'b01, 6'd40, 6'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[9]  = '{1'b1, 2'b00, 6'd40, 6'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[10] = '{1'b1, 2'b11, 6'd63, 6'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[11] = '{1'b1, 2'b10, 6'd0,  6'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[12] = '{1'b0, 2'b10, 6'd63, 6'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[13] = '{1'b1, 2'b10, 6'd63, 6'd10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1};

    // ---------------- reset with random inputs ----------------
    rst          = 1'b1;
    div_val      = 8'd0;
    attack_hold  = 8'($urandom);
    sustain_hold = 8'($urandom);
    applyStimulus(1'b1, 2'($urandom), 6'($urandom), 6'($urandom), 1'b1, 1'b1);
`ifdef TS_ONSET_COUNT_EN
    onset_clr = 1'b0;
`endif
    clockEdge();
    clockEdge();
    checkOutput("rst.core_ena", core_ena, 0);
    checkOutput("rst.attack", attack_amt, 0);
    checkOutput("rst.sustain", sustain_amt, 0);
    checkOutput("rst.state", state_o, 0);
    checkOutput("rst.onset", onset, 0);
`ifdef TS_ONSET_COUNT_EN
    checkOutput("rst.onset_count", onset_count, 0);
`endif

    // ---------------- strobe phase after release ----------------
    div_val = 8'd3;
    applyStimulus(1'b1, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      #1;
      checkOutput("phase.core_ena", core_ena, (k % 4 == 0) ? 1 : 0);
      clockEdge();
    end
    // Divider now sits at count 2; freeze it for 5 cycles and confirm it resumes.
    ena = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("gate.core_ena", core_ena, 0);
      clockEdge();
    end
    ena = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("resume.core_ena", core_ena, (k == 1) ? 1 : 0);
      clockEdge();
    end

    // ---------------- table vectors ----------------
    div_val      = 8'd0;
    attack_hold  = 8'd1;
    sustain_hold = 8'd1;
    applyStimulus(1'b1, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
    doReset();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i].e, tbl[i].m, tbl[i].a, tbl[i].t, tbl[i].ma, tbl[i].ms);
      #1;
      checkOutput($sformatf("tbl%0d.core_ena", i), core_ena, tbl[i].xCore);
      clockEdge();
      checkOutput($sformatf("tbl%0d.onset", i), onset, tbl[i].xOnset);
      checkOutput($sformatf("tbl%0d.attack", i), attack_amt, tbl[i].xAtt);
      checkOutput($sformatf("tbl%0d.sustain", i), sustain_amt, tbl[i].xSus);
      checkOutput($sformatf("tbl%0d.state", i), state_o, tbl[i].xSt);
    end

    // ---------------- burst timing: 3 attack + 4 sustain strobes ----------------
    attack_hold  = 8'd2;
    sustain_hold = 8'd3;
    applyStimulus(1'b1, 2'b10, 6'd0, 6'd10, 1'b0, 1'b0);
    doReset();
    clockEdge();
    audio_in = 6'd40;
    for (int k = 0; k < 9; k++) begin
      clockEdge();
      checkAuto("burst", (k < 3) ? 1 : (k < 7) ? 2 : 0, (k == 0) ? 1 : 0);
    end

    // ---------------- retrigger in ATTACK, onset on final SUSTAIN strobe ----------------
    auSeq = '{0, 40, 40, 0, 40, 40, 40, 40, 40, 40, 0, 40, 40, 40, 40};
    stSeq = '{0, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 2};
    onSeq = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    for (int k = 0; k < 15; k++) begin
      audio_in = 6'(auSeq[k]);
      clockEdge();
      checkAuto($sformatf("retrig%0d", k), stSeq[k], onSeq[k]);
    end

    // ---------------- mode switch mid-ATTACK ----------------
    audio_in = 6'd0;
    clockEdge();
    audio_in = 6'd40;
    clockEdge();
    checkAuto("pre_switch", 1, 1);
    applyStimulus(1'b1, 2'b01, 6'd40, 6'd10, 1'b0, 1'b1);
    clockEdge();
    checkOutput("switch.state", state_o, 0);
    checkOutput("switch.attack", attack_amt, 0);
    checkOutput("switch.sustain", sustain_amt, 1);
    applyStimulus(1'b1, 2'b10, 6'd40, 6'd10, 1'b0, 1'b0);
    clockEdge();
    checkAuto("back_auto", 0, 0);

`ifdef TS_ONSET_COUNT_EN
    // ---------------- saturating onset counter ----------------
    applyStimulus(1'b1, 2'b10, 6'd0, 6'd0, 1'b0, 1'b0);
    onset_clr = 1'b0;
    doReset();
    for (int k = 0; k < 600; k++) begin
      audio_in = (k % 2 == 1) ? 6'd63 : 6'd0;
      clockEdge();
    end
    checkOutput("ocnt.saturate", onset_count, 255);
    audio_in  = 6'd0;
    clockEdge();
    audio_in  = 6'd63;
    onset_clr = 1'b1;
    clockEdge();
    checkOutput("ocnt.clr_priority", onset_count, 0);
    onset_clr = 1'b0;
    audio_in  = 6'd0;
    clockEdge();
    audio_in  = 6'd63;
    clockEdge();
    checkOutput("ocnt.increment", onset_count, 1);
`endif

    // ---------------- randomized run against behavioural model ----------------
    div_val = 8'd0;
    applyStimulus(1'b1, 2'b10, 6'd0, 6'd0, 1'b0, 1'b0);
`ifdef TS_ONSET_COUNT_EN
    onset_clr = 1'b0;
`endif
    doReset();
    mDiv = 0; mPrev = 0; mSt = 0; mCnt = 0; mOns = 0; mAtt = 0; mSus = 0; mOcnt = 0;
    for (int i = 0; i < 2000; i++) begin
      bit strb, det, isAuto, clr;
      if (i % 64 == 0) div_val = 8'($urandom_range(0, 3));
      attack_hold  = 8'($urandom_range(0, 4));
      sustain_hold = 8'($urandom_range(0, 4));
      applyStimulus(($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 9) < 7) ? 2'b10 : 2'($urandom_range(0, 3)),
                    6'($urandom), 6'($urandom_range(0, 40)),
                    1'($urandom), 1'($urandom));
      clr = ($urandom_range(0, 49) == 0);
`ifdef TS_ONSET_COUNT_EN
      onset_clr = clr;
`endif
      #1;
      strb = ena && (mDiv == int'(div_val));
      checkOutput("rand.core_ena", core_ena, strb);

      if (ena) begin
        isAuto = (mode == 2'b10);
        det    = strb && ((int'(audio_in) - mPrev) > int'(thresh));
        if (!isAuto) begin
          mSt = 0; mCnt = 0;
        end else if (strb) begin
          if (det) begin
            mSt = 1; mCnt = int'(attack_hold);
          end else if (mSt != 0) begin
            if (mCnt > 0) mCnt--;
            else if (mSt == 1) begin mSt = 2; mCnt = int'(sustain_hold); end
            else mSt = 0;
          end
        end
        mOns = (isAuto && det) ? 1 : 0;
        mAtt = isAuto ? (mSt == 1) : (mode == 2'b01 && man_attack);
        mSus = isAuto ? (mSt == 2) : (mode == 2'b01 && man_sustain);
        if (clr) mOcnt = 0;
        else if (mOns == 1 && mOcnt < 255) mOcnt++;
        mDiv = strb ? 0 : (mDiv + 1) % 256;
        if (strb) mPrev = int'(audio_in);
      end

      clockEdge();
      checkOutput("rand.state", state_o, mSt);
      checkOutput("rand.attack", attack_amt, mAtt);
      checkOutput("rand.sustain", sustain_amt, mSus);
      checkOutput("rand.onset", onset, mOns);
`ifdef TS_ONSET_COUNT_EN
      checkOutput("rand.onset_count", onset_count, mOcnt);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
